// File: rtl/ubcd_scan_ctrl.sv
// Scan controller for a multiplexed 7-segment display that time-shares one universal BCD decoder.
// Digits are scanned MSD first, and the decoder's RBO is chained into the next digit's RBI.
module ubcd_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DWELL      = 256,
  parameter int GHOST      = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    value_wr,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    ctrl_wr,
  input  logic [9:0]              ctrl_in,
  output logic [3:0]              dec_value,
  output logic [2:0]              dec_version,
  output logic                    dec_x6,
  output logic                    dec_x7,
  output logic                    dec_x9,
  output logic                    dec_rbi,
  output logic                    dec_lt,
  output logic                    dec_bi,
  output logic                    dec_al,
  input  logic                    dec_rbo,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done,
  output logic                    busy
);

  localparam int VW   = 4 * NUM_DIGITS;
  localparam int IDXW = $clog2(NUM_DIGITS);
  localparam int CW   = $clog2((DWELL > GHOST) ? DWELL : GHOST);
  localparam logic [CW-1:0]   DWELL_LD = CW'(DWELL - 1);
  localparam logic [CW-1:0]   GHOST_LD = CW'(GHOST - 1);
  localparam logic [IDXW-1:0] MSD      = IDXW'(NUM_DIGITS - 1);
  localparam logic [9:0]      CTRL_RST = 10'h008;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t          state;
  logic            en_q;
  logic [9:1]      ctrl_sh;
  logic [VW-1:0]   value_sh;
  logic [VW-1:0]   value_act;
  logic [IDXW-1:0] idx;
  logic [CW-1:0]   cnt;
  logic            rb_chain;

  logic            en_eff;
  logic [9:1]      ctrl_next;
  logic [VW-1:0]   value_next;
  logic [3:0]      cur_nib;
  logic            frame_start;

  // A write landing on the frame-start cycle must be seen by that frame, so look through the shadows.
  always_comb begin
    en_eff      = ctrl_wr ? ctrl_in[0] : en_q;
    ctrl_next   = ctrl_wr ? ctrl_in[9:1] : ctrl_sh;
    value_next  = value_wr ? value_in : value_sh;
    cur_nib     = value_act[{idx, 2'b00} +: 4];
    frame_start = en_eff && ((state == IDLE) ||
                  ((state == SHOW) && (cnt == '0) && (idx == '0)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q     <= 1'b0;
      ctrl_sh  <= CTRL_RST[9:1];
      value_sh <= '0;
    end else begin
      if (ctrl_wr) begin
        en_q    <= ctrl_in[0];
        ctrl_sh <= ctrl_in[9:1];
      end
      if (value_wr) begin
        value_sh <= value_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      value_act   <= '0;
      idx         <= MSD;
      cnt         <= GHOST_LD;
      rb_chain    <= 1'b1;
      digit_en    <= '0;
      dec_bi      <= 1'b0;
      dec_value   <= 4'd0;
      dec_version <= 3'd0;
      dec_x6      <= 1'b0;
      dec_x7      <= 1'b0;
      dec_x9      <= 1'b0;
      dec_rbi     <= 1'b1;
      dec_lt      <= 1'b1;
      dec_al      <= 1'b1;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (frame_start) begin
        value_act   <= value_next;
        dec_version <= ctrl_next[6:4];
        dec_x6      <= ctrl_next[7];
        dec_x7      <= ctrl_next[8];
        dec_x9      <= ctrl_next[9];
        dec_al      <= ctrl_next[3];
        dec_lt      <= ~ctrl_next[2];
        idx         <= MSD;
        rb_chain    <= ~ctrl_next[1];
      end
      if (!en_eff) begin
        state    <= IDLE;
        cnt      <= GHOST_LD;
        digit_en <= '0;
        dec_bi   <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state <= BLANK;
            cnt   <= GHOST_LD;
            busy  <= 1'b1;
          end
          BLANK: begin
            if (cnt == '0) begin
              state     <= SHOW;
              cnt       <= DWELL_LD;
              digit_en  <= NUM_DIGITS'(1) << idx;
              dec_bi    <= 1'b1;
              dec_value <= cur_nib;
              dec_rbi   <= (idx == '0) | rb_chain;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          // The LSD always shows its zero; the chain restart for idx==0 comes from frame_start.
          SHOW: begin
            if (cnt == '0) begin
              state    <= BLANK;
              cnt      <= GHOST_LD;
              digit_en <= '0;
              dec_bi   <= 1'b0;
              if (idx == '0) begin
                frame_done <= 1'b1;
              end else begin
                idx      <= idx - IDXW'(1);
                rb_chain <= dec_rbo;
              end
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ubcd_scan_ctrl.sv
// Scoreboard bench for ubcd_scan_ctrl: stimulus pushes per-digit expectations derived from display rules,
// and a negedge monitor pops and compares them whenever a digit lights or frame_done pulses.
module tb_ubcd_scan_ctrl;

  localparam int N  = 4;
  localparam int DW = 256;
  localparam int GH = 2;
  localparam int P  = N * (GH + DW);

  logic           clk      = 1'b0;
  logic           rst_n    = 1'b0;
  logic           value_wr = 1'b0;
  logic [4*N-1:0] value_in = '0;
  logic           ctrl_wr  = 1'b0;
  logic [9:0]     ctrl_in  = '0;
  logic [3:0]     dec_value;
  logic [2:0]     dec_version;
  logic           dec_x6, dec_x7, dec_x9, dec_rbi, dec_lt, dec_bi, dec_al, dec_rbo;
  logic [N-1:0]   digit_en;
  logic           frame_done, busy;

  ubcd_scan_ctrl #(.NUM_DIGITS(N), .DWELL(DW), .GHOST(GH)) dut (
    .clk(clk), .rst_n(rst_n), .value_wr(value_wr), .value_in(value_in),
    .ctrl_wr(ctrl_wr), .ctrl_in(ctrl_in), .dec_value(dec_value), .dec_version(dec_version),
    .dec_x6(dec_x6), .dec_x7(dec_x7), .dec_x9(dec_x9), .dec_rbi(dec_rbi), .dec_lt(dec_lt),
    .dec_bi(dec_bi), .dec_al(dec_al), .dec_rbo(dec_rbo), .digit_en(digit_en),
    .frame_done(frame_done), .busy(busy)
  );

  // Decoder ripple-blank behaviour: RBO drops only for a blanked zero, and lamp test forces it high.
  assign dec_rbo = ~dec_lt | dec_rbi | (dec_value != 4'd0);

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         at;
    int         digit;
    logic [3:0] val;
    logic       rbi;
    logic       lt;
    logic       al;
    logic [2:0] ver;
    logic [2:0] xs;
  } exp_t;

  exp_t dq[$];
  int   fdq[$];

  logic [4*N-1:0] m_val  = '0;
  logic [9:0]     m_ctrl = 10'h008;
  bit             m_run  = 1'b0;
  int             m_bound = 0;
  int             m_fstart = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic flagFail(input string name, input int act, input int want);
    total++;
    bad++;
    $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, want, cyc);
  endtask

  // Expected frame from display rules: leading zeros blank while lzb is on, lamp test lights everything past the MSD.
  task automatic pushFrame(input int x, input bit first);
    exp_t e;
    bit   seen_nz = 1'b0;
    for (int k = 0; k < N; k++) begin
      e.digit = N - 1 - k;
      e.at    = x + 1 + GH + k * (GH + DW);
      e.val   = m_val[4*e.digit +: 4];
      e.rbi   = (e.digit == 0) || !m_ctrl[1] || ((e.digit < N - 1) && (m_ctrl[2] || seen_nz));
      e.lt    = ~m_ctrl[2];
      e.al    = m_ctrl[3];
      e.ver   = m_ctrl[6:4];
      e.xs    = m_ctrl[9:7];
      if (e.val != 4'd0) seen_nz = 1'b1;
      dq.push_back(e);
    end
    if (!first) fdq.push_back(x + 1);
    m_fstart = x;
    m_bound  = x + P;
  endtask

  task automatic flushAfter(input int x);
    while (dq.size() > 0 && dq[$].at > x) void'(dq.pop_back());
    while (fdq.size() > 0 && fdq[$] > x) void'(fdq.pop_back());
  endtask

  task automatic applyStimulus(input bit vw, input logic [4*N-1:0] v, input bit cw, input logic [9:0] c);
    @(negedge clk);
    value_wr = vw;
    value_in = v;
    ctrl_wr  = cw;
    ctrl_in  = c;
    if (vw) m_val = v;
    if (cw) m_ctrl = c;
    if (cw && !c[0]) begin
      if (m_run) flushAfter(cyc);
      m_run = 1'b0;
    end else if (m_run && cyc == m_bound) begin
      pushFrame(cyc, 1'b0);
    end else if (cw && c[0] && !m_run) begin
      m_run = 1'b1;
      pushFrame(cyc, 1'b1);
    end
  endtask

  task automatic runUntil(input int t);
    while (cyc + 1 < t) applyStimulus(1'b0, '0, 1'b0, '0);
  endtask

  task automatic resetChecks();
    checkOutput("rst_digit_en", 32'(digit_en), 0);
    checkOutput("rst_dec_bi", 32'(dec_bi), 0);
    checkOutput("rst_dec_value", 32'(dec_value), 0);
    checkOutput("rst_dec_version", 32'(dec_version), 0);
    checkOutput("rst_dec_x", 32'({dec_x9, dec_x7, dec_x6}), 0);
    checkOutput("rst_dec_rbi", 32'(dec_rbi), 1);
    checkOutput("rst_dec_lt", 32'(dec_lt), 1);
    checkOutput("rst_dec_al", 32'(dec_al), 1);
    checkOutput("rst_frame_done", 32'(frame_done), 0);
    checkOutput("rst_busy", 32'(busy), 0);
  endtask

  function automatic logic [4*N-1:0] randValue();
    logic [4*N-1:0] v;
    int lz;
    lz = $urandom_range(0, N);
    for (int d = 0; d < N; d++) v[4*d +: 4] = (d >= N - lz) ? 4'd0 : 4'($urandom_range(0, 9));
    return v;
  endfunction

  function automatic logic [9:0] randCtrl(input bit en);
    logic [9:0] c;
    c    = 10'($urandom);
    c[0] = en;
    c[1] = ($urandom_range(0, 3) != 0);
    c[2] = ($urandom_range(0, 5) == 0);
    return c;
  endfunction

  // Monitor: every rising digit_en is one scoreboard entry; every frame_done pulse is another.
  logic [N-1:0] prev_en = '0;
  exp_t         me;
  int           didx;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_en = '0;
    end else begin
      if (digit_en != '0 && prev_en == '0) begin
        if (dq.size() == 0) begin
          flagFail("unexpected_digit", int'(digit_en), 0);
        end else begin
          me = dq.pop_front();
          didx = -1;
          for (int i = 0; i < N; i++) if (digit_en[i]) didx = i;
          checkOutput("digit_onehot", 32'($countones(digit_en)), 1);
          checkOutput("digit_start_cycle", 32'(cyc), 32'(me.at));
          checkOutput("digit_index", 32'(didx), 32'(me.digit));
          checkOutput("dec_value", 32'(dec_value), 32'(me.val));
          checkOutput("dec_rbi", 32'(dec_rbi), 32'(me.rbi));
          checkOutput("dec_lt", 32'(dec_lt), 32'(me.lt));
          checkOutput("dec_al", 32'(dec_al), 32'(me.al));
          checkOutput("dec_version", 32'(dec_version), 32'(me.ver));
          checkOutput("dec_x", 32'({dec_x9, dec_x7, dec_x6}), 32'(me.xs));
          checkOutput("show_dec_bi", 32'(dec_bi), 1);
          checkOutput("show_busy", 32'(busy), 1);
        end
      end
      if (frame_done) begin
        if (fdq.size() == 0) flagFail("frame_done_unexpected", cyc, -1);
        else checkOutput("frame_done_cycle", 32'(cyc), 32'(fdq.pop_front()));
      end
      if (dq.size() > 0 && dq[0].at < cyc) begin
        flagFail("digit_missing", cyc, dq[0].at);
        void'(dq.pop_front());
      end
      if (fdq.size() > 0 && fdq[0] < cyc) begin
        flagFail("frame_done_missing", cyc, fdq[0]);
        void'(fdq.pop_front());
      end
      prev_en = digit_en;
    end
  end

  initial begin : stim
    bit             vw, cw;
    logic [9:0]     c;
    int             off;
    repeat (3) @(negedge clk);
    resetChecks();
    rst_n = 1'b1;
    repeat (2) applyStimulus(1'b0, '0, 1'b0, '0);

    applyStimulus(1'b0, '0, 1'b1, 10'h001);
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("busy_after_enable", 32'(busy), 1);
    checkOutput("blank_digit_en", 32'(digit_en), 0);

    runUntil(m_fstart + 100);
    applyStimulus(1'b1, 16'h0042, 1'b1, 10'h003);
    runUntil(m_bound + 1);
    runUntil(m_fstart + 300);
    applyStimulus(1'b1, 16'h0000, 1'b0, '0);
    runUntil(m_bound + 1);
    runUntil(m_fstart + 300);
    applyStimulus(1'b0, '0, 1'b1, 10'h001);
    runUntil(m_bound + 1);
    runUntil(m_fstart + 300);
    applyStimulus(1'b1, 16'h5678, 1'b0, '0);
    runUntil(m_bound + 1);
    runUntil(m_fstart + 500);
    applyStimulus(1'b1, 16'h1234, 1'b0, '0);
    runUntil(m_bound + 1);
    runUntil(m_fstart + 200);
    applyStimulus(1'b0, '0, 1'b1, 10'h071);
    runUntil(m_bound);
    applyStimulus(1'b1, 16'h0907, 1'b0, '0);
    runUntil(m_fstart + 200);
    applyStimulus(1'b1, 16'h0030, 1'b1, 10'h007);
    runUntil(m_bound + 1);

    runUntil(m_fstart + 1 + GH + (GH + DW) + 50);
    applyStimulus(1'b0, '0, 1'b1, 10'h006);
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("disable_digit_en", 32'(digit_en), 0);
    checkOutput("disable_dec_bi", 32'(dec_bi), 0);
    checkOutput("disable_busy", 32'(busy), 0);
    repeat (5) applyStimulus(1'b0, '0, 1'b0, '0);
    applyStimulus(1'b0, '0, 1'b1, 10'h003);

    runUntil(m_fstart + 400);
    applyStimulus(1'b0, '0, 1'b0, '0);
    #2 rst_n = 1'b0;
    #1 resetChecks();
    dq.delete();
    fdq.delete();
    m_val  = '0;
    m_ctrl = 10'h008;
    m_run  = 1'b0;
    repeat (3) applyStimulus(1'b0, '0, 1'b0, '0);
    rst_n = 1'b1;
    repeat (2) applyStimulus(1'b0, '0, 1'b0, '0);

    applyStimulus(1'b1, randValue(), 1'b1, randCtrl(1'b1));
    off = 0;
    for (int i = 0; i < 12 * P; i++) begin
      vw = ($urandom_range(0, 499) == 0) || (m_run && cyc + 1 == m_bound && $urandom_range(0, 2) == 0);
      cw = ($urandom_range(0, 799) == 0);
      c  = randCtrl(1'b1);
      if (off > 0) begin
        off--;
        cw = (off == 0);
      end else if (m_run && $urandom_range(0, 2999) == 0) begin
        cw  = 1'b1;
        c   = randCtrl(1'b0);
        off = 4;
      end
      applyStimulus(vw, randValue(), cw, c);
    end

    applyStimulus(1'b0, '0, 1'b1, 10'h000);
    repeat (4) applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("leftover_digits", 32'(dq.size()), 0);
    checkOutput("leftover_frame_done", 32'(fdq.size()), 0);
    checkOutput("busy_final", 32'(busy), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ubcd_scan_ctrl.md
Name: ubcd_scan_ctrl

Overview:
- Time-multiplexed scan controller for a multi-digit 7-segment display built around one shared universal BCD decoder.
- Holds a packed BCD value and decoder configuration, and steps through the digits MSD first.
- Drives the decoder inputs and one-hot digit enables, and chains the decoder's RBO back into the next digit's RBI for leading-zero blanking.
- Sits between the tinyQV peripheral register interface and the decoder/pad outputs.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8); value width is 4*NUM_DIGITS
DWELL, 256, clock cycles each digit is lit (>=2)
GHOST, 2, blank cycles between digits, for anti-ghosting (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
value_wr  in  1  write strobe for value_in into the shadow value register
value_in  in  4*NUM_DIGITS  packed BCD; nibble i = digit i; digit 0 = LSD
ctrl_wr  in  1  write strobe for ctrl_in
ctrl_in  in  10  [0]enable [1]lzb_en [2]lamp_test [3]al [6:4]version [7]x6 [8]x7 [9]x9
dec_value  out  4  {D,C,B,A} to the decoder
dec_version  out  3  {V2,V1,V0}
dec_x6, dec_x7, dec_x9  out  1 each  glyph style selects
dec_rbi  out  1  ripple-blank input to the decoder
dec_lt  out  1  lamp test, active-low
dec_bi  out  1  blanking input, active-low (0 = blank)
dec_al  out  1  active-level select
dec_rbo  in  1  ripple-blank output returned from the decoder
digit_en  out  NUM_DIGITS  one-hot digit common drive
frame_done  out  1  1-cycle pulse after the LSD dwell completes
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: digit_en=0, dec_bi=0, dec_value=0, dec_version=0, dec_x*=0, dec_rbi=1, dec_lt=1, dec_al=1, frame_done=0, busy=0.
  - Internal: shadow and active value = 0; ctrl register = 10'h008; state = IDLE.
  - Reset mid-frame aborts immediately and produces no frame_done.
- ctrl register:
  - Written on ctrl_wr in the next cycle.
  - enable takes effect immediately. All other ctrl fields go to a ctrl shadow and become active only at frame boundaries.
- Value shadowing:
  - value_wr updates the shadow only.
  - Shadow is copied to active at each frame start, so no tearing within a frame.
  - If value_wr coincides with a frame-start copy, the copy uses value_in (write wins).
- State machine:
  - IDLE -> BLANK when enable=1. The shadow copy happens on this transition; digit index idx=NUM_DIGITS-1; rb_chain=~lzb_en.
  - BLANK: digit_en=0 and dec_bi=0 for GHOST cycles, then -> SHOW.
  - SHOW: digit_en[idx]=1 and dec_bi=1 for DWELL cycles.
    - dec_value = active nibble idx.
    - dec_rbi = 1 if idx==0 (the LSD always shows "0"), else rb_chain.
    - dec_lt = ~lamp_test; dec_al, dec_version and dec_x* come from active ctrl.
  - Last SHOW cycle:
    - rb_chain <= dec_rbo, sampled combinationally from the decoder that cycle.
    - If idx>0: idx--, -> BLANK.
    - If idx==0: frame_done=1 next cycle, shadow->active copy, idx=NUM_DIGITS-1, rb_chain=~lzb_en, -> BLANK.
  - enable=0 in any state -> IDLE on the next cycle: digit_en=0, dec_bi=0, no frame_done. Re-enable restarts at the MSD.
- Timing: frame period = NUM_DIGITS*(GHOST+DWELL) cycles. digit_en is registered and is never more than one-hot.
- Counter: one dwell counter, width clog2(max(DWELL,GHOST)). It reloads on every state change and never wraps within a state.
- Lamp test: forces dec_lt=0 but keeps the normal scan. The decoder lights all segments and forces RBO high, which disables blanking.

Test Plan:
- Reset with NUM_DIGITS=4: all outputs hold their reset values. Write ctrl=0x001 -> BLANK 2 cycles, then digit_en=4'b1000 for 256 cycles; frame_done pulses at cycle 1+4*258.
- value=0x0042, ctrl=0x003 (lzb on), decoder model in loop -> digit 3 has dec_rbi=0 (blanked); digit 2 has dec_rbi=0 from RBO; digit 1 shows 4; digit 0 shows 2.
- value=0x0000 with lzb on -> digits 3..1 blank; digit 0 gets dec_rbi=1 and shows 0. Same with lzb off -> all digits get dec_rbi=1.
- Write value=0x1234 mid-frame -> the current frame keeps the old value; the next frame shows 1234. value_wr on the frame-boundary cycle -> the new value appears in that frame.
- Clear enable during SHOW of digit 2 -> next cycle digit_en=0, dec_bi=0, busy=0, no frame_done. Re-enable -> restarts at digit 3.
- ctrl write of version=7, al=0 mid-frame -> dec_version and dec_al change only after frame_done. lamp_test=1 -> dec_lt=0 on all digits.
